// File: rtl/sm_uart_tx_hex.sv
// UART 8N1 transmitter that prints a 32-bit word as 8 uppercase hex digits,
// MSB nibble first, optionally followed by CR LF.
module sm_uart_tx_hex #(
  parameter int BAUD_DIV = 868,
  parameter int CRLF     = 1
) (
  input  logic        clkIn,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] number,
  output logic        busy,
  output logic        done,
  output logic        tx
);
  // state | meaning
  // IDLE  | line high, waiting for start
  // START | start bit (tx=0) of the current character
  // DATA  | 8 data bits, LSB first
  // STOP  | stop bit (tx=1); then next character or back to IDLE

  localparam int         NCHAR     = 8 + 2 * CRLF;
  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [3:0]  LAST_CHAR = 4'(NCHAR - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t      state;
  logic [15:0] baudCnt;
  logic [2:0]  bitIdx;
  logic [3:0]  charIdx;
  logic [31:0] numLatched;

  logic [31:0] shifted;
  logic [3:0]  nib;
  logic [7:0]  curByte;
  logic        baudTc;

  // Character for the current index; stable for the whole character.
  always_comb begin
    shifted = numLatched << {charIdx[2:0], 2'b00};
    nib     = shifted[31:28];
    curByte = 8'h00;
    if (charIdx == 4'd8)      curByte = 8'h0D;
    else if (charIdx == 4'd9) curByte = 8'h0A;
    else if (nib < 4'd10)     curByte = 8'h30 + {4'h0, nib};
    else                      curByte = 8'h37 + {4'h0, nib};
  end

  assign baudTc = (baudCnt == BAUD_LAST);

  always_ff @(posedge clkIn or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      baudCnt    <= 16'd0;
      bitIdx     <= 3'd0;
      charIdx    <= 4'd0;
      numLatched <= 32'd0;
      busy       <= 1'b0;
      done       <= 1'b0;
      tx         <= 1'b1;
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          numLatched <= number;
          charIdx    <= 4'd0;
          bitIdx     <= 3'd0;
          baudCnt    <= 16'd0;
          busy       <= 1'b1;
          tx         <= 1'b0;
          state      <= START;
        end
      end else if (!baudTc) begin
        baudCnt <= baudCnt + 16'd1;
      end else begin
        baudCnt <= 16'd0;
        unique case (state)
          START: begin
            bitIdx <= 3'd0;
            tx     <= curByte[0];
            state  <= DATA;
          end
          DATA: begin
            if (bitIdx == 3'd7) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bitIdx <= bitIdx + 3'd1;
              tx     <= curByte[bitIdx + 3'd1];
            end
          end
          STOP: begin
            if (charIdx == LAST_CHAR) begin
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end else begin
              charIdx <= charIdx + 4'd1;
              tx      <= 1'b0;
              state   <= START;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_sm_uart_tx_hex.sv
// Bench for sm_uart_tx_hex: two instances (BAUD_DIV=4/CRLF=1 and BAUD_DIV=2/CRLF=0)
// compared against an expected-waveform and receiver model built from the word.
module tb_sm_uart_tx_hex;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start1 = 1'b0, start2 = 1'b0;
  logic [31:0] num1 = '0, num2 = '0;
  logic        busy1, done1, tx1, busy2, done2, tx2;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  sm_uart_tx_hex #(.BAUD_DIV(4), .CRLF(1)) dut (
    .clkIn(clk), .rst(rst), .start(start1), .number(num1),
    .busy(busy1), .done(done1), .tx(tx1)
  );

  sm_uart_tx_hex #(.BAUD_DIV(2), .CRLF(0)) dut2 (
    .clkIn(clk), .rst(rst), .start(start2), .number(num2),
    .busy(busy2), .done(done2), .tx(tx2)
  );

  function automatic logic txOf(bit sel);   return sel ? tx2 : tx1;     endfunction
  function automatic logic busyOf(bit sel); return sel ? busy2 : busy1; endfunction
  function automatic logic doneOf(bit sel); return sel ? done2 : done1; endfunction

  task automatic driveStart(bit sel, logic s);
    if (sel) start2 = s; else start1 = s;
  endtask

  task automatic driveNum(bit sel, logic [31:0] n);
    if (sel) num2 = n; else num1 = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Text the terminal should receive for word n.
  function automatic string expStr(bit sel, logic [31:0] n);
    string hexDigits = "0123456789ABCDEF";
    string s = "";
    int nibVal;
    for (int i = 0; i < 8; i++) begin
      nibVal = int'(n[31 - 4*i -: 4]);
      s = {s, hexDigits.substr(nibVal, nibVal)};
    end
    if (!sel) s = {s, "\r\n"};
    return s;
  endfunction

  // Leaves the bench at the sample point of frame cycle 0 (just after the accepting edge).
  task automatic accept(bit sel, logic [31:0] n, bit hold);
    driveNum(sel, n);
    driveStart(sel, 1'b1);
    tick();
    if (!hold) driveStart(sel, 1'b0);
  endtask

  task automatic checkFrame(input bit sel, input string s, input bit hold,
                            input logic [31:0] nextN, input string name);
    int   div, frameLen, errs, pos, bitN, diffAt;
    logic expBits[$];
    logic b;
    byte  ch;
    string got;
    div = sel ? 2 : 4;
    for (int k = 0; k < s.len(); k++) begin
      ch = s[k];
      for (int j = 0; j < 10; j++) begin
        b = (j == 0) ? 1'b0 : (j == 9) ? 1'b1 : ch[j-1];
        repeat (div) expBits.push_back(b);
      end
    end
    frameLen = expBits.size();
    errs = 0;
    got = "";
    ch = 8'h00;
    for (int c = 0; c < frameLen; c++) begin
      if (txOf(sel) !== expBits[c] || busyOf(sel) !== 1'b1 || doneOf(sel) !== 1'b0) begin
        if (errs == 0)
          $display("FAIL %s wave: cycle %0d tx=%b busy=%b done=%b, need tx=%b busy=1 done=0",
                   name, c, txOf(sel), busyOf(sel), doneOf(sel), expBits[c]);
        errs++;
      end
      pos  = c % (10 * div);
      bitN = pos / div;
      if (pos % div == div / 2 && bitN >= 1 && bitN <= 8) ch[bitN-1] = txOf(sel);
      if (pos == 10 * div - 1) got = $sformatf("%s%c", got, ch);
      driveNum(sel, $urandom);
      tick();
    end
    total++;
    if (errs !== 0) begin
      bad++;
      $display("FAIL %s wave: %0d bad cycles, need 0", name, errs);
    end
    total++;
    if (got != s) begin
      bad++;
      diffAt = 0;
      while (diffAt < got.len() && diffAt < s.len() && got[diffAt] == s[diffAt]) diffAt++;
      $display("FAIL %s decode: got %0d chars, need %0d; first diff at %0d got 0x%02h need 0x%02h",
               name, got.len(), s.len(), diffAt,
               (diffAt < got.len()) ? got[diffAt] : 8'h00,
               (diffAt < s.len()) ? s[diffAt] : 8'h00);
    end
    total++;
    if (busyOf(sel) !== 1'b0 || doneOf(sel) !== 1'b1 || txOf(sel) !== 1'b1) begin
      bad++;
      $display("FAIL %s end: at cycle %0d busy=%b done=%b tx=%b, need busy=0 done=1 tx=1",
               name, frameLen, busyOf(sel), doneOf(sel), txOf(sel));
    end
    driveNum(sel, nextN);
    tick();
    total++;
    if (hold) begin
      if (txOf(sel) !== 1'b0 || busyOf(sel) !== 1'b1 || doneOf(sel) !== 1'b0) begin
        bad++;
        $display("FAIL %s restart: busy=%b done=%b tx=%b, need busy=1 done=0 tx=0",
                 name, busyOf(sel), doneOf(sel), txOf(sel));
      end
      driveStart(sel, 1'b0);
    end else begin
      if (txOf(sel) !== 1'b1 || busyOf(sel) !== 1'b0 || doneOf(sel) !== 1'b0) begin
        bad++;
        $display("FAIL %s after: busy=%b done=%b tx=%b, need busy=0 done=0 tx=1",
                 name, busyOf(sel), doneOf(sel), txOf(sel));
      end
    end
  endtask

  task automatic test_reset();
    int errs;
    rst = 1'b1;
    repeat (3) tick();
    total++;
    if (tx1 !== 1'b1 || tx2 !== 1'b1) begin
      bad++; $display("FAIL reset tx: got %b/%b, need 1/1", tx1, tx2);
    end
    total++;
    if (busy1 !== 1'b0 || busy2 !== 1'b0 || done1 !== 1'b0 || done2 !== 1'b0) begin
      bad++; $display("FAIL reset busy/done: got %b%b/%b%b, need 00/00", busy1, done1, busy2, done2);
    end
    rst = 1'b0;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0 ||
          tx2 !== 1'b1 || busy2 !== 1'b0 || done2 !== 1'b0) errs++;
      tick();
    end
    total++;
    if (errs !== 0) begin
      bad++; $display("FAIL idle: %0d bad cycles, need 0", errs);
    end
  endtask

  task automatic test_basic();
    accept(0, 32'h1234ABCD, 0);
    checkFrame(0, expStr(0, 32'h1234ABCD), 0, 32'h0, "basic");
  endtask

  task automatic test_patterns();
    logic [31:0] n;
    accept(0, 32'h00000000, 0);
    checkFrame(0, expStr(0, 32'h00000000), 0, 32'h0, "zeros");
    accept(0, 32'hFFFFFFFF, 0);
    checkFrame(0, expStr(0, 32'hFFFFFFFF), 0, 32'h0, "ones");
    for (int i = 0; i < 3; i++) begin
      n = $urandom;
      repeat ($urandom_range(0, 5)) tick();
      accept(0, n, 0);
      checkFrame(0, expStr(0, n), 0, 32'h0, "random");
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] n1, n2;
    n1 = $urandom;
    n2 = $urandom;
    accept(0, n1, 1);
    checkFrame(0, expStr(0, n1), 1, n2, "b2b_first");
    checkFrame(0, expStr(0, n2), 0, 32'h0, "b2b_second");
  endtask

  task automatic test_mid_reset();
    logic [31:0] n;
    accept(0, $urandom, 0);
    repeat (150) tick();
    #2 rst = 1'b1;
    #1;
    total++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++; $display("FAIL midreset async: tx=%b busy=%b done=%b, need 1 0 0", tx1, busy1, done1);
    end
    tick();
    rst = 1'b0;
    tick();
    total++;
    if (tx1 !== 1'b1 || busy1 !== 1'b0 || done1 !== 1'b0) begin
      bad++; $display("FAIL midreset idle: tx=%b busy=%b done=%b, need 1 0 0", tx1, busy1, done1);
    end
    n = $urandom;
    accept(0, n, 0);
    checkFrame(0, expStr(0, n), 0, 32'h0, "after_reset");
  endtask

  task automatic test_no_crlf();
    accept(1, 32'hDEADBEEF, 0);
    checkFrame(1, expStr(1, 32'hDEADBEEF), 0, 32'h0, "no_crlf");
  endtask

  initial begin
    #1;
    test_reset();
    test_basic();
    test_patterns();
    test_back_to_back();
    test_mid_reset();
    test_no_crlf();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
